pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised WIDTH-bit adder split into STAGES carry-pipelined slices with valid/ready handshake.
//  Each stage adds one WIDTH/STAGES-bit slice built from full-adder cells; the carry is registered between stages.
//  Throughput is one add per clock; latency is STAGES cycles.
//  Serves as the datapath adder for wide accumulators and ALUs where a single-cycle ripple-carry adder misses timing.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be a multiple of STAGES
//  STAGES   4  pipeline stages; slice width SW = WIDTH/STAGES; STAGES=1 gives a single registered adder
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      adder accepts operands this cycle
//  a          in   WIDTH  operand A, unsigned/two's complement
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  sub        in   1      subtract select; present only with ADDER_SUB_EN
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  A+B+cin, modulo 2^WIDTH
//  cout       out  1      carry out of MSB
//  ovf        out  1      signed overflow: a[MSB]==b'[MSB] && sum[MSB]!=a[MSB], where b' is the effective B
// BEHAVIOUR
//  - Reset: all valid bits, data registers, carries, sum, cout and ovf are 0. in_ready=1 once rst_n deasserts.
//  - Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages shift only when adv=1.
//  - Accept on in_valid && in_ready. The beat enters stage 0 at that edge.
//  - Stage k (0..STAGES-1) adds slice k of A and B with the carry registered from stage k-1 (cin for k=0).
//    It registers the slice sum and the carry out.
//  - Input skew: slice k of A/B is delayed k cycles in skew registers.
//  - Output deskew: slice k of the sum is delayed STAGES-1-k cycles, so all slices of a beat leave together.
//  - Latency: a beat accepted at edge t has out_valid=1 after edge t+STAGES-1 when no stall occurs.
//  - Bubbles: stages shift with valid=0 when in_valid=0. Valid bits track each beat, with no gaps or duplication.
//  - Stall: while out_valid && !out_ready, every register holds, and sum/cout/ovf stay stable until the handshake.
//  - Simultaneous events: when the output handshake and input accept happen in the same cycle, both occur at full rate.
//  - Reset mid-operation: asserting rst_n low asynchronously clears all in-flight beats. No partial result is emitted.
//  - Arithmetic: sum={carries, slices} truncated to WIDTH. cout is the final stage carry. ovf uses the MSB of the effective operand.
// CONFIGURATION
//  ADDER_SUB_EN defined:
//   - The sub port exists and travels with the beat.
//   - When sub=1, the effective B is ~b and the stage-0 carry is ~cin. Result: sum = a - b - cin.
//   - cout=1 means no borrow.
//   - When sub=0, behaviour is identical to the add-only build.
//  ADDER_SUB_EN undefined: no sub port; the adder is add-only. Effective B is b and carry-in is cin.
// STRUCTURE
//  - Shared package pipelined_adder_pkg:
//    - localparam function for SW;
//    - typedef for the per-stage record {valid, sub, carry};
//    - elaboration check that WIDTH % STAGES == 0.
//  - Sub-module fa_cell: a 1-bit full adder (a, b, ci -> s, co).
//    It is instantiated SW times per stage in a generate loop; the stage logic surrounds it.
// TESTING
//  1. Reset, then a=0xFFFF, b=0x0001, cin=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0.
//  2. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also 0x1234+0x4321+cin=1 -> 0x5556.
//  3. Stream 8 back-to-back beats with out_ready=1:
//     - in_ready stays 1;
//     - results appear in order on 8 consecutive cycles starting at cycle 4.
//  4. Hold out_ready=0 for 5 cycles with the pipe full:
//     - in_ready=0;
//     - sum, cout and ovf stay constant;
//     - on release, no beat is lost or duplicated.
//  5. Pull rst_n low with 3 beats in flight -> out_valid=0 immediately and sum=0. After release, the first new beat has latency 4.
//  6. (ADDER_SUB_EN) sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0; a=0x0009, b=0x0003 -> sum=0x0006, cout=1.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared types and sizing helpers for the carry-pipelined adder.
package pipelined_adder_pkg;

  // Control record that travels with a beat from stage to stage.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } stage_rec_t;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit slice_ok(input int width, input int stages);
    return (stages > 0) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_fa_cell.sv
// One-bit full adder; the building block of every adder slice.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-pipelined slices with valid/ready flow control.
// Define ADDER_SUB_EN to add the sub port (sum = a - b - cin when sub=1).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (!slice_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic             sub_in;
  logic             ovf_p;
  stage_rec_t       rec_p [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

`ifdef ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stage_rec_t       r_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic [SW-1:0]    bx;
    logic [SW-1:0]    sl;
    logic [SW:0]      c;

    // Operands shift down one slice per stage, so slice k is always at the bottom at stage k.
    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b;
      assign s_in = '0;
      assign r_in = '{valid: in_valid, sub: sub_in, carry: cin ^ sub_in};
    end else begin : g_body
      assign a_in = a_p[k-1];
      assign b_in = b_p[k-1];
      assign s_in = s_p[k-1];
      assign r_in = rec_p[k-1];
    end

    assign bx   = b_in[SW-1:0] ^ {SW{r_in.sub}};
    assign c[0] = r_in.carry;

    for (genvar j = 0; j < SW; j++) begin : g_fa
      fa_cell u_fa (
        .a  (a_in[j]),
        .b  (bx[j]),
        .ci (c[j]),
        .s  (sl[j]),
        .co (c[j+1])
      );
    end

    // Stage k -> k+1: new slice enters at the top of the sum, earlier slices move down.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rec_p[k] <= '0;
        s_p[k]   <= '0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
      end else if (adv) begin
        rec_p[k] <= '{valid: r_in.valid, sub: r_in.sub, carry: c[SW]};
        s_p[k]   <= (s_in >> SW) | (WIDTH'(sl) << (WIDTH - SW));
        a_p[k]   <= a_in >> SW;
        b_p[k]   <= b_in >> SW;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_p <= 1'b0;
        end else if (adv) begin
          ovf_p <= signed_ovf(a_in[SW-1], bx[SW-1], sl[SW-1]);
        end
      end
    end
  end

  assign out_valid = rec_p[STAGES-1].valid;
  assign cout      = rec_p[STAGES-1].carry;
  assign sum       = s_p[STAGES-1];
  assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors plus randomized traffic vs a queue model.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin       = 1'b0;
  logic         sub_r     = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic         cout;
  logic         ovf;
  logic [W-1:0] sum;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];
  res_t exp_r;
  bit   take;
  bit   acc;
  bit   have_exp;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_SUB_EN
    .sub       (sub_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: plain wide addition on the effective operands.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mci, input logic msb);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   full;
    res_t         r;
    be     = msb ? ~mb : mb;
    ce     = msb ? ~mci : mci;
    full   = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ce};
    r.s    = full[W-1:0];
    r.co   = full[W];
    r.ov   = (ma[W-1] == be[W-1]) && (r.s[W-1] != ma[W-1]);
    return r;
  endfunction

  // Drive one cycle of inputs after the edge, then observe mid-cycle which handshakes the next edge takes.
  task automatic tick(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                      input logic tci, input logic tsb, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = ta;
    b         = tb2;
    cin       = tci;
    sub_r     = tsb;
    out_ready = ordy;
    @(negedge clk);
    take     = (out_valid === 1'b1) && (out_ready === 1'b1);
    acc      = (in_valid === 1'b1) && (in_ready === 1'b1);
    have_exp = 1'b0;
    if (take && exp_q.size() > 0) begin
      exp_r    = exp_q.pop_front();
      have_exp = 1'b1;
    end
    if (acc) exp_q.push_back(model(a, b, cin, sub_r));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b sum=%h cout=%b ovf=%b, need all zero", out_valid, sum, cout, ovf);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b need 0", out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W-1:0] es [4];
    logic         ec [4];
    logic         eo [4];
    va = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000};
    vb = '{16'h0001, 16'h0001, 16'h4321, 16'h8000};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0};
    es = '{16'h0000, 16'h8000, 16'h5556, 16'h0000};
    ec = '{1'b1, 1'b0, 1'b0, 1'b1};
    eo = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, va[i], vb[i], vc[i], 1'b0, 1'b1);
      n_tests++;
      if (!acc) begin
        n_fail++;
        $display("FAIL vec_accept[%0d]: operands not accepted", i);
      end
      for (int d = 1; d <= S; d++) begin
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (d < S) begin
          if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL vec_early[%0d]: out_valid=%b at cycle %0d, need 0", i, out_valid, d);
          end
        end else if (out_valid !== 1'b1 || sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
          n_fail++;
          $display("FAIL vec_result[%0d]: got vld=%b sum=%h cout=%b ovf=%b need 1/%h/%b/%b",
                   i, out_valid, sum, cout, ovf, es[i], ec[i], eo[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int           n_out;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    logic         v;
    n_out = 0;
    for (int i = 0; i < 8 + S + 2; i++) begin
      v  = (i < 8);
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'b0;
`ifdef ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      tick(v, ra, rb, rc, rs, 1'b1);
      if (v) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready: beat %0d saw in_ready=%b, need 1", i, in_ready);
        end
      end
      if (take) begin
        n_tests++;
        if (!have_exp || {sum, cout, ovf} !== exp_r) begin
          n_fail++;
          $display("FAIL b2b_data: got sum=%h cout=%b ovf=%b need %h/%b/%b (expected present=%b)",
                   sum, cout, ovf, exp_r.s, exp_r.co, exp_r.ov, have_exp);
        end
        n_tests++;
        if (i != S + n_out) begin
          n_fail++;
          $display("FAIL b2b_timing: result %0d at cycle %0d, need cycle %0d", n_out, i, S + n_out);
        end
        n_out++;
      end
    end
    n_tests++;
    if (n_out != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results need 8", n_out);
    end
  endtask

  task automatic test_stall();
    int           n_acc;
    int           n_out;
    res_t         held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    n_acc = 0;
    n_out = 0;
    held  = '0;
    for (int i = 0; i < S + 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'b0;
`ifdef ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      tick(1'b1, ra, rb, rc, rs, 1'b0);
      if (acc) n_acc++;
      if (i == S) held = {sum, cout, ovf};
      if (i >= S) begin
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_ctrl: cycle %0d got in_ready=%b out_valid=%b need 0/1", i, in_ready, out_valid);
        end
      end
      if (i > S) begin
        n_tests++;
        if ({sum, cout, ovf} !== held) begin
          n_fail++;
          $display("FAIL stall_hold: cycle %0d got %h/%b/%b need %h/%b/%b", i, sum, cout, ovf,
                   held.s, held.co, held.ov);
        end
      end
    end
    n_tests++;
    if (n_acc != S) begin
      n_fail++;
      $display("FAIL stall_fill: accepted %0d beats need %0d", n_acc, S);
    end
    for (int i = 0; i < S + 4; i++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (take) begin
        n_out++;
        n_tests++;
        if (!have_exp || {sum, cout, ovf} !== exp_r) begin
          n_fail++;
          $display("FAIL stall_data: got %h/%b/%b need %h/%b/%b (expected present=%b)",
                   sum, cout, ovf, exp_r.s, exp_r.co, exp_r.ov, have_exp);
        end
      end
    end
    n_tests++;
    if (n_out != S || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_release: got %0d results need %0d, %0d left over", n_out, S, exp_q.size());
    end
  endtask

  task automatic test_reset_flight();
    res_t         r;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom) | 16'h0100;
      rb = W'($urandom);
      tick(1'b1, ra, rb, 1'b0, 1'b0, 1'b1);
    end
    @(posedge clk);
    #2;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flight_pre: got out_valid=%b need 1 before reset", out_valid);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL flight_clear: got vld=%b sum=%h cout=%b ovf=%b need all zero", out_valid, sum, cout, ovf);
    end
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    ra = W'($urandom);
    rb = W'($urandom);
    r  = model(ra, rb, 1'b1, 1'b0);
    tick(1'b1, ra, rb, 1'b1, 1'b0, 1'b1);
    for (int d = 1; d <= S; d++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (d < S) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL flight_early: out_valid=%b at cycle %0d after reset, need 0", out_valid, d);
        end
      end else if (out_valid !== 1'b1 || {sum, cout, ovf} !== r) begin
        n_fail++;
        $display("FAIL flight_first: got vld=%b %h/%b/%b need 1/%h/%b/%b", out_valid, sum, cout, ovf,
                 r.s, r.co, r.ov);
      end
    end
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    logic [W-1:0] es [2];
    logic         ec [2];
    va = '{16'h0005, 16'h0009};
    vb = '{16'h0007, 16'h0003};
    es = '{16'hFFFE, 16'h0006};
    ec = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, va[i], vb[i], 1'b0, 1'b1, 1'b1);
      for (int d = 1; d <= S; d++) tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (out_valid !== 1'b1 || sum !== es[i] || cout !== ec[i]) begin
        n_fail++;
        $display("FAIL sub_result[%0d]: got vld=%b sum=%h cout=%b need 1/%h/%b", i, out_valid, sum, cout,
                 es[i], ec[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int           n_out;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    logic         v;
    logic         o;
    n_out = 0;
    for (int i = 0; i < 300 + S + 6; i++) begin
      v  = (i < 300) && ($urandom_range(0, 99) < 70);
      o  = (i >= 300) || ($urandom_range(0, 99) < 70);
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'b0;
`ifdef ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      tick(v, ra, rb, rc, rs, o);
      if (take) begin
        n_out++;
        n_tests++;
        if (!have_exp || {sum, cout, ovf} !== exp_r) begin
          n_fail++;
          $display("FAIL rand_data: result %0d got %h/%b/%b need %h/%b/%b (expected present=%b)",
                   n_out, sum, cout, ovf, exp_r.s, exp_r.co, exp_r.ov, have_exp);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d beats still expected, out_valid=%b, need 0/0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_flight();
`ifdef ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
